// File: rtl/bcd_updown_counter_pkg.sv
// Package bcd_pkg: shared BCD digit type, digit range limits and the clamp
// helper used when presetting a digit from an arbitrary nibble.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Non-BCD nibbles (10..15) saturate to 9 so stored digits are always valid.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// Module: bcd_digit_ud
// One BCD digit of the up/down counter. Steps by one in the requested
// direction, wrapping 9->0 going up and 0->9 going down. The parent decides
// when this digit steps (carry/borrow chain and saturation).
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load, load_digit    synchronous preset; load_digit clamped to 0..9
//   step, up            step request and direction (1 = increment)
//   digit               current digit value
//   at_max, at_min      digit == 9 / digit == 0
module bcd_digit_ud
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t digit,
    output logic       at_max,
    output logic       at_min
);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= bcd_clamp(load_digit);
        end else if (step) begin
            if (up) begin
                digit <= at_max ? BCD_MIN : digit + 4'd1;
            end else begin
                digit <= at_min ? BCD_MAX : digit - 4'd1;
            end
        end
    end

    assign at_max = (digit == BCD_MAX);
    assign at_min = (digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Module: bcd_updown_counter
// Multi-digit BCD up/down counter with synchronous load, wrap or saturate at
// the range ends, and registered one-cycle ovf/udf pulses.
// Optional feature: define BCD_CNT_MATCH_EN to enable the match pulse; when
// undefined, match is tied low and match_val is unused.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   count, up    step request and direction (1 = increment)
//   sat          0 = wrap at range ends, 1 = saturate
//   load         synchronous preset of load_val (wins over count)
//   load_val     BCD preset, digit i at [4i+3:4i]; nibbles >9 clamp to 9
//   match_val    BCD compare value (BCD_CNT_MATCH_EN only)
//   bcd          current count
//   is_zero      combinational bcd == 0
//   ovf, udf     registered pulse: step hit top / bottom of range
//   match        registered pulse: bcd changed to equal match_val
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                count,
    input  logic                up,
    input  logic                sat,
    input  logic                load,
    input  logic [DIGITS*4-1:0] load_val,
    input  logic [DIGITS*4-1:0] match_val,
    output logic [DIGITS*4-1:0] bcd,
    output logic                is_zero,
    output logic                ovf,
    output logic                udf,
    output logic                match
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step_d;
    logic [DIGITS:0]   carry;
    logic [DIGITS:0]   borrow;
    logic              at_top;
    logic              at_bottom;
    logic              hold;
    logic              do_step;

    // carry[i]: all digits below i are 9; borrow[i]: all digits below i are 0.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign carry[gi+1]  = carry[gi] & at_max[gi];
            assign borrow[gi+1] = borrow[gi] & at_min[gi];
            assign step_d[gi]   = do_step & (up ? carry[gi] : borrow[gi]);

            bcd_digit_ud u_digit (
                .clk        (clk),
                .rst        (rst),
                .load       (load),
                .load_digit (load_val[4*gi +: 4]),
                .step       (step_d[gi]),
                .up         (up),
                .digit      (bcd[4*gi +: 4]),
                .at_max     (at_max[gi]),
                .at_min     (at_min[gi])
            );
        end
    endgenerate

    assign at_top    = carry[DIGITS];
    assign at_bottom = borrow[DIGITS];
    // Saturation suppresses the step entirely at the relevant range end.
    assign hold      = sat & (up ? at_top : at_bottom);
    assign do_step   = count & ~load & ~hold;
    assign is_zero   = at_bottom;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= count & ~load & up & at_top;
            udf <= count & ~load & ~up & at_bottom;
        end
    end

`ifdef BCD_CNT_MATCH_EN
    // Predict the post-edge value so the pulse lands in the cycle right after
    // bcd takes on match_val.
    logic [DIGITS*4-1:0] bcd_nxt;

    always_comb begin
        bcd_nxt = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (load) begin
                bcd_nxt[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
            end else if (step_d[i]) begin
                if (up) begin
                    bcd_nxt[4*i +: 4] = at_max[i] ? BCD_MIN : bcd[4*i +: 4] + 4'd1;
                end else begin
                    bcd_nxt[4*i +: 4] = at_min[i] ? BCD_MAX : bcd[4*i +: 4] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match <= 1'b0;
        end else begin
            match <= (bcd_nxt != bcd) && (bcd_nxt == match_val);
        end
    end
`else
    logic unused_match_val;
    assign unused_match_val = ^match_val;
    assign match            = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

    localparam int DIGITS = 3;

    logic                clk;
    logic                rst;
    logic                count;
    logic                up;
    logic                sat;
    logic                load;
    logic [DIGITS*4-1:0] load_val;
    logic [DIGITS*4-1:0] match_val;
    logic [DIGITS*4-1:0] bcd;
    logic                is_zero;
    logic                ovf;
    logic                udf;
    logic                match;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_updown_counter #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .up        (up),
        .sat       (sat),
        .load      (load),
        .load_val  (load_val),
        .match_val (match_val),
        .bcd       (bcd),
        .is_zero   (is_zero),
        .ovf       (ovf),
        .udf       (udf),
        .match     (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply current inputs across one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; count = 0; load = 0;
    endtask

    task automatic do_load(input logic [11:0] v);
        idle();
        load = 1; load_val = v;
        tick();
        load = 0;
    endtask

    task automatic do_step(input logic dir, input logic s);
        idle();
        count = 1; up = dir; sat = s;
        tick();
        count = 0;
    endtask

    initial begin
        rst = 1; count = 0; up = 1; sat = 0; load = 0;
        load_val = '0; match_val = 12'h005;
        tick();
        chk("rst_bcd", bcd, 12'h000);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        chk("rst_match", match, 0);
        chk("rst_zero", is_zero, 1);

        // 1. reset mid-count
        do_load(12'h457);
        do_step(1, 0);
        chk("cnt_458", bcd, 12'h458);
        idle(); count = 1; up = 1; rst = 1;
        tick();
        chk("midrst_bcd", bcd, 12'h000);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_udf", udf, 0);
        chk("midrst_match", match, 0);

        // 2. carry and borrow across digits
        do_load(12'h099);
        chk("load_099", bcd, 12'h099);
        do_step(1, 0);
        chk("up_100", bcd, 12'h100);
        chk("up_100_ovf", ovf, 0);
        do_step(0, 0);
        chk("dn_099", bcd, 12'h099);
        chk("dn_099_udf", udf, 0);

        // 3. top of range
        do_load(12'h999);
        do_step(1, 0);
        chk("wrap_top_bcd", bcd, 12'h000);
        chk("wrap_top_ovf", ovf, 1);
        chk("wrap_top_udf", udf, 0);
        idle(); tick();
        chk("wrap_top_ovf_fall", ovf, 0);
        chk("wrap_top_hold", bcd, 12'h000);
        do_load(12'h999);
        do_step(1, 1);
        chk("sat_top_bcd", bcd, 12'h999);
        chk("sat_top_ovf", ovf, 1);
        idle(); tick();
        chk("sat_top_ovf_fall", ovf, 0);

        // 4. bottom of range
        do_load(12'h000);
        do_step(0, 0);
        chk("wrap_bot_bcd", bcd, 12'h999);
        chk("wrap_bot_udf", udf, 1);
        chk("wrap_bot_ovf", ovf, 0);
        idle(); tick();
        chk("wrap_bot_udf_fall", udf, 0);
        do_load(12'h000);
        do_step(0, 1);
        chk("sat_bot_bcd", bcd, 12'h000);
        chk("sat_bot_udf", udf, 1);
        chk("sat_bot_zero", is_zero, 1);
        idle(); tick();
        chk("sat_bot_udf_fall", udf, 0);

        // 5. clamp and load priority
        do_load(12'hA5F);
        chk("clamp_959", bcd, 12'h959);
        chk("nz_959", is_zero, 0);
        idle(); load = 1; load_val = 12'h123; count = 1; up = 1;
        tick();
        chk("ld_cnt_bcd", bcd, 12'h123);
        idle(); load = 1; load_val = 12'h999; count = 1; up = 1;
        tick();
        chk("ld_cnt_999", bcd, 12'h999);
        chk("ld_cnt_noovf", ovf, 0);
        do_load(12'h100);
        do_step(0, 1);
        chk("borrow_099", bcd, 12'h099);

        // 6. match pulse at 005
        do_load(12'h000);
        for (int k = 1; k <= 7; k++) begin
            idle(); count = 1; up = 1; sat = 0;
            tick();
            chk("seq_bcd", bcd, 32'(k));
`ifdef BCD_CNT_MATCH_EN
            chk("seq_match", match, (k == 5) ? 1 : 0);
`else
            chk("seq_match", match, 0);
`endif
        end
        do_load(12'h005);
`ifdef BCD_CNT_MATCH_EN
        chk("ld_match", match, 1);
`else
        chk("ld_match", match, 0);
`endif
        idle(); tick();
        chk("hold_match", match, 0);
        do_load(12'h005);
        chk("reload_same_match", match, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
